fir_interp3_polyphase: RTL and testbench

- Transmit-side counterpart of the 21-tap low-pass FIR decimation path: upsamples an 8-bit unsigned sample stream by 3.
- Uses a 3-phase polyphase decomposition of the same 21 symmetric coefficients, computed on one time-multiplexed multiplier-accumulator.
- Sits between the sample source and the DAC/output formatter, with valid/ready handshakes on both sides.

---
 rtl/fir_interp3_polyphase_if.sv | 30 +++
 rtl/fir_interp3_polyphase.sv | 130 +++++++++++++
 tb/tb_fir_interp3_polyphase.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_interp3_polyphase_if.sv
// rtl/fir_interp3_polyphase_if.sv - sample-in / interpolated-out handshake bundle for fir_interp3_polyphase
// FLUSH is present only when FIR_INTERP3_FLUSH_EN is defined.
interface fir_interp3_polyphase_if;
    logic [7:0]  FIR_IN;
    logic        IN_VALID;
    logic        IN_READY;
    logic [16:0] FIR_OUT;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [1:0]  OUT_PHASE;
`ifdef FIR_INTERP3_FLUSH_EN
    logic        FLUSH;
`endif

    modport master (
        output FIR_IN, IN_VALID, OUT_READY,
`ifdef FIR_INTERP3_FLUSH_EN
        output FLUSH,
`endif
        input  IN_READY, FIR_OUT, OUT_VALID, OUT_PHASE
    );

    modport slave (
        input  FIR_IN, IN_VALID, OUT_READY,
`ifdef FIR_INTERP3_FLUSH_EN
        input  FLUSH,
`endif
        output IN_READY, FIR_OUT, OUT_VALID, OUT_PHASE
    );
endinterface

// File: rtl/fir_interp3_polyphase.sv
// rtl/fir_interp3_polyphase.sv - x3 polyphase FIR interpolator, 21 symmetric taps on one shared MAC
// Optional FLUSH input (delay-line clear in IDLE) enabled by FIR_INTERP3_FLUSH_EN.
module fir_interp3_polyphase (
    input  logic                     CLK,
    input  logic                     RST,
    fir_interp3_polyphase_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, HOLD = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [7:0]  x_q [0:6];
    logic [16:0] acc_q;
    logic [16:0] fir_out_q;
    logic        out_valid_q;
    logic [1:0]  out_phase_q;
    logic [1:0]  phase_q;
    logic [2:0]  tap_q;

    logic        flush;
    logic        accept;
    logic        out_hs;
    logic [4:0]  coef_idx;
    logic [5:0]  h_sel;
    logic [7:0]  x_sel;
    logic [13:0] prod;
    logic [16:0] acc_sum;

    function automatic logic [5:0] coef(input logic [4:0] idx);
        case (idx)
            5'd0,  5'd20: coef = 6'd3;
            5'd1,  5'd19: coef = 6'd4;
            5'd2,  5'd18: coef = 6'd6;
            5'd3,  5'd17: coef = 6'd10;
            5'd4,  5'd16: coef = 6'd15;
            5'd5,  5'd15: coef = 6'd20;
            5'd6,  5'd14: coef = 6'd25;
            5'd7,  5'd13: coef = 6'd30;
            5'd8,  5'd12: coef = 6'd34;
            5'd9,  5'd11: coef = 6'd36;
            5'd10:        coef = 6'd37;
            default:      coef = 6'd0;
        endcase
    endfunction

`ifdef FIR_INTERP3_FLUSH_EN
    assign flush = bus.FLUSH;
`else
    assign flush = 1'b0;
`endif

    assign bus.IN_READY  = (state_q == IDLE) & ~flush;
    assign bus.FIR_OUT   = fir_out_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_PHASE = out_phase_q;

    assign accept = bus.IN_VALID & bus.IN_READY;
    assign out_hs = (state_q == HOLD) & out_valid_q & bus.OUT_READY;

    // Branch p uses every third coefficient: h[3*tap + p] against x[tap].
    assign coef_idx = ({2'b00, tap_q} * 5'd3) + {3'b000, phase_q};
    assign h_sel    = coef(coef_idx);
    assign x_sel    = x_q[tap_q];
    assign prod     = {8'd0, h_sel} * {6'd0, x_sel};
    assign acc_sum  = acc_q + {3'd0, prod};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = MAC;
            MAC:     if (tap_q == 3'd6) state_d = HOLD;
            HOLD:    if (out_hs) state_d = (phase_q == 2'd2) ? IDLE : MAC;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < 7; k++) x_q[k] <= 8'd0;
            acc_q       <= 17'd0;
            fir_out_q   <= 17'd0;
            out_valid_q <= 1'b0;
            out_phase_q <= 2'd0;
            phase_q     <= 2'd0;
            tap_q       <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        for (int k = 0; k < 7; k++) x_q[k] <= 8'd0;
                    end else if (accept) begin
                        x_q[0] <= bus.FIR_IN;
                        for (int k = 1; k < 7; k++) x_q[k] <= x_q[k-1];
                        phase_q <= 2'd0;
                        tap_q   <= 3'd0;
                        acc_q   <= 17'd0;
                    end
                end
                MAC: begin
                    if (tap_q == 3'd6) begin
                        fir_out_q   <= acc_sum;
                        out_valid_q <= 1'b1;
                        out_phase_q <= phase_q;
                    end else begin
                        acc_q <= acc_sum;
                        tap_q <= tap_q + 3'd1;
                    end
                end
                HOLD: begin
                    if (out_hs) begin
                        out_valid_q <= 1'b0;
                        if (phase_q != 2'd2) begin
                            phase_q <= phase_q + 2'd1;
                            tap_q   <= 3'd0;
                            acc_q   <= 17'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_interp3_polyphase.sv
// tb/tb_fir_interp3_polyphase.sv - self-checking bench for fir_interp3_polyphase
module tb_fir_interp3_polyphase;
    logic CLK = 1'b0;
    logic RST;

    fir_interp3_polyphase_if bus();

    fir_interp3_polyphase dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int din;
        int e [3];
    } vec_t;

    vec_t tbl [15];
    int   n_total = 0;
    int   n_pass  = 0;
    int   h [21]  = '{3, 4, 6, 10, 15, 20, 25, 30, 34, 36, 37, 36, 34, 30, 25, 20, 15, 10, 6, 4, 3};
    int   hist [7];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int model_y(input int p);
        int s = 0;
        for (int m = 0; m < 7; m++) s += h[3*m + p] * hist[m];
        return s;
    endfunction

    task automatic push(input int s);
        for (int k = 6; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = s;
    endtask

    task automatic clear_hist();
        for (int k = 0; k < 7; k++) hist[k] = 0;
    endtask

    task automatic set_row(input int i, input int d, input int e0, input int e1, input int e2);
        tbl[i].din  = d;
        tbl[i].e[0] = e0;
        tbl[i].e[1] = e1;
        tbl[i].e[2] = e2;
    endtask

    task automatic send(input int s);
        bit ok = 1'b0;
        @(negedge CLK);
        bus.FIR_IN   = 8'(s);
        bus.IN_VALID = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            if (bus.IN_READY) begin
                @(posedge CLK);
                #1;
                ok = 1'b1;
            end else begin
                @(negedge CLK);
            end
        end
        bus.IN_VALID = 1'b0;
        if (ok) push(s);
        else chk("send_timeout", 0, 1);
    endtask

    task automatic recv(input bit rnd, output int v, output int ph);
        bit got = 1'b0;
        v  = -1;
        ph = -1;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge CLK);
            bus.OUT_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.OUT_VALID && bus.OUT_READY) begin
                v  = int'(bus.FIR_OUT);
                ph = int'(bus.OUT_PHASE);
                @(posedge CLK);
                #1;
                got = 1'b1;
            end
        end
        bus.OUT_READY = 1'b0;
        if (!got) chk("recv_timeout", 0, 1);
    endtask

    task automatic sample_vs_model(input int s, input bit rnd, input string tag);
        int v, ph;
        send(s);
        for (int p = 0; p < 3; p++) begin
            recv(rnd, v, ph);
            chk($sformatf("%s_val_p%0d", tag, p), v, model_y(p));
            chk($sformatf("%s_phase_p%0d", tag, p), ph, p);
        end
    endtask

    initial begin
        int v, ph, cnt, stable, pc, cur, rem;
        int acc_q[$];
        int hs_q[$];

        // Impulse response then full-scale DC ramp from zero history.
        set_row(0, 1, 3, 4, 6);
        set_row(1, 0, 10, 15, 20);
        set_row(2, 0, 25, 30, 34);
        set_row(3, 0, 36, 37, 36);
        set_row(4, 0, 34, 30, 25);
        set_row(5, 0, 20, 15, 10);
        set_row(6, 0, 6, 4, 3);
        set_row(7, 255, 765, 1020, 1530);
        set_row(8, 255, 3315, 4845, 6630);
        set_row(9, 255, 9690, 12495, 15300);
        set_row(10, 255, 18870, 21930, 24480);
        set_row(11, 255, 27540, 29580, 30855);
        set_row(12, 255, 32640, 33405, 33405);
        set_row(13, 255, 34170, 34425, 34170);
        set_row(14, 255, 34170, 34425, 34170);

        clear_hist();
        RST           = 1'b1;
        bus.FIR_IN    = 8'd0;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b0;
`ifdef FIR_INTERP3_FLUSH_EN
        bus.FLUSH     = 1'b0;
`endif
        #12;
        chk("rst_in_ready", int'(bus.IN_READY), 1);
        chk("rst_out_valid", int'(bus.OUT_VALID), 0);
        chk("rst_fir_out", int'(bus.FIR_OUT), 0);
        chk("rst_out_phase", int'(bus.OUT_PHASE), 0);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 15; i++) begin
            send(tbl[i].din);
            for (int p = 0; p < 3; p++) begin
                recv(1'b0, v, ph);
                chk($sformatf("tbl%0d_val_p%0d", i, p), v, tbl[i].e[p]);
                chk($sformatf("tbl%0d_phase_p%0d", i, p), ph, p);
            end
        end

        // Backpressure on phase 1.
        send(77);
        recv(1'b0, v, ph);
        chk("bp_p0_val", v, model_y(0));
        cnt = 0;
        while (!bus.OUT_VALID && cnt < 50) begin
            @(negedge CLK);
            cnt++;
        end
        chk("bp_p1_seen", int'(bus.OUT_VALID), 1);
        v  = int'(bus.FIR_OUT);
        ph = int'(bus.OUT_PHASE);
        stable = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (int'(bus.FIR_OUT) != v || int'(bus.OUT_PHASE) != ph ||
                bus.OUT_VALID != 1'b1 || bus.IN_READY != 1'b0) stable = 0;
        end
        chk("bp_stable", stable, 1);
        chk("bp_p1_val", v, model_y(1));
        chk("bp_p1_phase", ph, 1);
        bus.OUT_READY = 1'b1;
        cnt = 0;
        do begin
            @(negedge CLK);
            cnt++;
        end while (!bus.OUT_VALID && cnt < 50);
        chk("bp_p2_gap", cnt, 8);
        chk("bp_p2_val", int'(bus.FIR_OUT), model_y(2));
        chk("bp_p2_phase", int'(bus.OUT_PHASE), 2);
        @(posedge CLK);
        #1;
        bus.OUT_READY = 1'b0;

        // Throughput with both handshakes held high.
        pc  = 0;
        cur = $urandom_range(0, 255);
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge CLK);
            bus.IN_VALID  = 1'b1;
            bus.FIR_IN    = 8'(cur);
            bus.OUT_READY = 1'b1;
            if (bus.IN_READY) begin
                acc_q.push_back(cyc);
                push(cur);
                cur = $urandom_range(0, 255);
            end
            if (bus.OUT_VALID) begin
                hs_q.push_back(cyc);
                chk("tput_val", int'(bus.FIR_OUT), model_y(pc % 3));
                chk("tput_phase", int'(bus.OUT_PHASE), pc % 3);
                pc++;
            end
        end
        @(negedge CLK);
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b0;
        chk("tput_accepts", acc_q.size(), 4);
        for (int i = 1; i < acc_q.size(); i++) chk("tput_in_gap", acc_q[i] - acc_q[i-1], 25);
        if (acc_q.size() > 0 && hs_q.size() > 0) chk("tput_first_out", hs_q[0] - acc_q[0], 8);
        for (int i = 1; i < hs_q.size(); i++)
            chk("tput_out_gap", hs_q[i] - hs_q[i-1], ((i % 3) == 0) ? 9 : 8);
        rem = 3 * acc_q.size() - pc;
        for (int i = 0; i < rem; i++) begin
            recv(1'b0, v, ph);
            chk("tput_drain_val", v, model_y(pc % 3));
            pc++;
        end

        // Randomized samples with random gaps and random output backpressure.
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            sample_vs_model($urandom_range(0, 255), 1'b1, "rand");
        end

        // Asynchronous reset while an output is held.
        send(50);
        cnt = 0;
        while (!bus.OUT_VALID && cnt < 50) begin
            @(negedge CLK);
            cnt++;
        end
        chk("pre_rst_valid", int'(bus.OUT_VALID), 1);
        #2;
        RST = 1'b1;
        #1;
        chk("mid_rst_fir_out", int'(bus.FIR_OUT), 0);
        chk("mid_rst_valid", int'(bus.OUT_VALID), 0);
        chk("mid_rst_phase", int'(bus.OUT_PHASE), 0);
        chk("mid_rst_in_ready", int'(bus.IN_READY), 1);
        @(negedge CLK);
        RST = 1'b0;
        clear_hist();
        send(100);
        for (int p = 0; p < 3; p++) begin
            recv(1'b0, v, ph);
            chk($sformatf("post_rst_p%0d", p), v, 100 * h[p]);
        end

`ifdef FIR_INTERP3_FLUSH_EN
        for (int i = 0; i < 7; i++) sample_vs_model(255, 1'b0, "fl_load");
        @(negedge CLK);
        bus.FLUSH    = 1'b1;
        bus.IN_VALID = 1'b1;
        bus.FIR_IN   = 8'd9;
        #1;
        chk("flush_in_ready", int'(bus.IN_READY), 0);
        @(negedge CLK);
        bus.FLUSH    = 1'b0;
        bus.IN_VALID = 1'b0;
        clear_hist();
        for (int p = 0; p < 3; p++) begin
            if (p == 0) send(0);
            recv(1'b0, v, ph);
            chk($sformatf("flush_out_p%0d", p), v, 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
